multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Multi-cycle control FSM for the 16-bit processor; the other end of the ALU interface.
- Decodes the opcode from the instruction register and sequences fetch/decode/execute/memory/writeback.
- Drives a 4-bit ALU operation code and all datapath selects and enables.
- Consumes the ALU Zero/Negative/Carry flags for conditional branches and the carry status bit.

Parameters:
- PC_INCR, 2, PC increment in bytes; informational only, the constant is supplied by the datapath on ALUSrcB=01.

Ports:
- CLK  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- input_Opcode  in  4  IR[15:12]; valid from the DECODE state onward
- input_MemReady  in  1  memory completes the current access this cycle
- input_Zero  in  1  ALU zero flag
- input_Negative  in  1  ALU negative flag
- input_Carry  in  1  ALU carry flag
- output_ALUOp  out  4  operation code to the ALU
- output_ALUSrcA  out  1  0=PC, 1=reg A
- output_ALUSrcB  out  2  00=reg B, 01=constant 2, 10=sign-extended imm, 11=sign-extended imm<<1
- output_PCWrite  out  1  PC load enable
- output_PCSource  out  2  00=ALU result, 01=ALUOut register, 10=jump target
- output_IorD  out  1  memory address: 0=PC, 1=ALUOut
- output_MemRead  out  1  memory read request
- output_MemWrite  out  1  memory write request
- output_IRWrite  out  1  instruction register load
- output_RegWrite  out  1  register file write
- output_MemToReg  out  1  writeback source: 0=ALUOut, 1=MDR
- output_CarryFlag  out  1  registered carry status
- output_Halted  out  1  high in HALT

Behaviour:
- Opcodes:
  - 0x0-0x8: R-type. output_ALUOp = opcode (add, sub, and, or, xor, sll, srl, sla, sra).
  - 0x9: ADDI. 0xA: LW. 0xB: SW. 0xC: BEQ. 0xD: BLT. 0xE: J. 0xF: HALT.
- Opcode latching: the opcode is captured into an internal register on the DECODE cycle. All later states use the latched value.
- Outputs: combinational from the state and latched opcode. Every output not listed for a state is 0, with ALUOp=0000.
- Reset (async): state=RESET, all outputs 0, output_CarryFlag=0. RESET -> FETCH on the next edge.
- FETCH:
  - Drives MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=0000, PCSource=00.
  - PCWrite=1 and IRWrite=1 only in the cycle with input_MemReady=1; otherwise stays in FETCH with PCWrite=IRWrite=0.
  - Transitions to DECODE on ready.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=0000 (branch target into ALUOut). Next state by opcode:
  - R-type -> EXEC_R
  - 0x9 -> EXEC_I
  - 0xA/0xB -> MEM_ADDR
  - 0xC/0xD -> BRANCH
  - 0xE -> JUMP
  - 0xF -> HALT
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=latched opcode. If the opcode is 0x0 or 0x1, output_CarryFlag <= input_Carry on this edge; otherwise it holds. -> ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=0000. CarryFlag <= input_Carry. -> ALU_WB.
- ALU_WB: RegWrite=1, MemToReg=0. -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=0000. -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: MemRead=1, IorD=1. Holds until input_MemReady=1, then -> MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1. -> FETCH.
- MEM_WR: MemWrite=1, IorD=1. Holds until ready, then -> FETCH.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=0001 (A-B), PCSource=01.
  - PCWrite = input_Zero for BEQ, input_Negative for BLT; combinational in the same cycle.
  - -> FETCH.
- JUMP: PCWrite=1, PCSource=10. -> FETCH.
- HALT: output_Halted=1, all enables 0. Absorbing; only Reset exits.
- Latency with zero wait states:
  - R-type/ADDI: 4 cycles. LW: 5. SW: 4. Branch/jump: 3.
  - Each memory wait cycle adds 1.
- Reset mid-instruction: any state returns to RESET immediately. No write enable may be high after Reset asserts.
- Unreachable state encodings -> RESET on the next edge.

Test Plan:
- Reset asserted mid-EXEC_R -> all outputs 0 the same cycle; FETCH one edge after deassert; CarryFlag=0.
- Opcode 0x1 (sub), MemReady=1 -> sequence FETCH, DECODE, EXEC_R (ALUOp=0001, SrcA=1, SrcB=00), ALU_WB (RegWrite=1); Carry=1 in EXEC_R -> CarryFlag=1 afterwards.
- LW with MemReady low 3 cycles in MEM_RD -> MemRead=1, IorD=1 held 4 cycles; MEM_WB RegWrite=1, MemToReg=1; total 8 cycles.
- BEQ with Zero=1 -> PCWrite=1, PCSource=01 in BRANCH; repeat with Zero=0 -> PCWrite=0; BLT with Negative=1 -> PCWrite=1.
- FETCH with MemReady=0 for 2 cycles -> PCWrite=IRWrite=0 those cycles; exactly one PCWrite pulse on the ready cycle.
- Opcode 0xF -> Halted=1 indefinitely with no enables; Reset -> RESET then FETCH.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the 16-bit processor.
// Sequences fetch / decode / execute / memory / writeback and drives the
// ALU operation code together with every datapath select and enable.
//
// Ports:
//   CLK, Reset        clock (rising edge), asynchronous active-high reset
//   input_Opcode      IR[15:12], sampled on the DECODE cycle
//   input_MemReady    memory completes the current access this cycle
//   input_Zero/Negative/Carry  ALU flags
//   output_ALUOp      4-bit ALU operation
//   output_ALUSrcA/B  ALU operand selects
//   output_PCWrite, output_PCSource   PC load enable and source select
//   output_IorD, output_MemRead, output_MemWrite   memory interface
//   output_IRWrite, output_RegWrite, output_MemToReg   register loads
//   output_CarryFlag  registered carry status
//   output_Halted     high while halted
module multicycle_control_unit #(
  parameter int PC_INCR = 2
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [3:0] input_Opcode,
  input  logic       input_MemReady,
  input  logic       input_Zero,
  input  logic       input_Negative,
  input  logic       input_Carry,
  output logic [3:0] output_ALUOp,
  output logic       output_ALUSrcA,
  output logic [1:0] output_ALUSrcB,
  output logic       output_PCWrite,
  output logic [1:0] output_PCSource,
  output logic       output_IorD,
  output logic       output_MemRead,
  output logic       output_MemWrite,
  output logic       output_IRWrite,
  output logic       output_RegWrite,
  output logic       output_MemToReg,
  output logic       output_CarryFlag,
  output logic       output_Halted
);

  // The increment constant itself lives in the datapath (ALUSrcB=01);
  // this unit only assumes the 16-bit instruction width.
  if (PC_INCR != 2) begin : g_pc_incr_check
    $error("multicycle_control_unit assumes PC_INCR == 2");
  end

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_ALU_WB   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_MEM_WB   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'h9;
  localparam logic [3:0] OP_LW   = 4'hA;
  localparam logic [3:0] OP_SW   = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_BLT  = 4'hD;
  localparam logic [3:0] OP_J    = 4'hE;

  state_t     state;
  logic [3:0] opcode;

  // State sequencing, opcode latch and carry status.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state            <= S_RESET;
      opcode           <= 4'h0;
      output_CarryFlag <= 1'b0;
    end else begin
      case (state)
        S_RESET:  state <= S_FETCH;
        S_FETCH:  if (input_MemReady) state <= S_DECODE;
        S_DECODE: begin
          // The latch is not visible until the next cycle, so dispatch on
          // the live IR field here.
          opcode <= input_Opcode;
          if (input_Opcode <= 4'h8)                               state <= S_EXEC_R;
          else if (input_Opcode == OP_ADDI)                       state <= S_EXEC_I;
          else if (input_Opcode == OP_LW || input_Opcode == OP_SW) state <= S_MEM_ADDR;
          else if (input_Opcode == OP_BEQ || input_Opcode == OP_BLT) state <= S_BRANCH;
          else if (input_Opcode == OP_J)                          state <= S_JUMP;
          else                                                    state <= S_HALT;
        end
        S_EXEC_R: begin
          // Only add and sub produce a meaningful carry.
          if (opcode <= 4'h1) output_CarryFlag <= input_Carry;
          state <= S_ALU_WB;
        end
        S_EXEC_I: begin
          output_CarryFlag <= input_Carry;
          state <= S_ALU_WB;
        end
        S_ALU_WB:   state <= S_FETCH;
        S_MEM_ADDR: state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (input_MemReady) state <= S_MEM_WB;
        S_MEM_WB:   state <= S_FETCH;
        S_MEM_WR:   if (input_MemReady) state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JUMP:     state <= S_FETCH;
        S_HALT:     state <= S_HALT;
        default:    state <= S_RESET;
      endcase
    end
  end

  // Datapath controls decoded from state and latched opcode.
  always_comb begin
    output_ALUOp    = 4'h0;
    output_ALUSrcA  = 1'b0;
    output_ALUSrcB  = 2'b00;
    output_PCWrite  = 1'b0;
    output_PCSource = 2'b00;
    output_IorD     = 1'b0;
    output_MemRead  = 1'b0;
    output_MemWrite = 1'b0;
    output_IRWrite  = 1'b0;
    output_RegWrite = 1'b0;
    output_MemToReg = 1'b0;
    output_Halted   = 1'b0;
    case (state)
      S_FETCH: begin
        output_MemRead = 1'b1;
        output_ALUSrcB = 2'b01;
        // PC+2 and the IR load commit only when the fetch completes.
        output_PCWrite = input_MemReady;
        output_IRWrite = input_MemReady;
      end
      S_DECODE: output_ALUSrcB = 2'b11;
      S_EXEC_R: begin
        output_ALUSrcA = 1'b1;
        output_ALUOp   = opcode;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        output_ALUSrcA = 1'b1;
        output_ALUSrcB = 2'b10;
      end
      S_ALU_WB: output_RegWrite = 1'b1;
      S_MEM_RD: begin
        output_MemRead = 1'b1;
        output_IorD    = 1'b1;
      end
      S_MEM_WB: begin
        output_RegWrite = 1'b1;
        output_MemToReg = 1'b1;
      end
      S_MEM_WR: begin
        output_MemWrite = 1'b1;
        output_IorD     = 1'b1;
      end
      S_BRANCH: begin
        output_ALUSrcA  = 1'b1;
        output_ALUOp    = 4'h1;
        output_PCSource = 2'b01;
        output_PCWrite  = (opcode == OP_BEQ) ? input_Zero : input_Negative;
      end
      S_JUMP: begin
        output_PCWrite  = 1'b1;
        output_PCSource = 2'b10;
      end
      S_HALT:  output_Halted = 1'b1;
      default: ;
    endcase
  end

endmodule
